// File: rtl/game_pkg.sv
// Shared constants for the vertical-scroll game: screen geometry, platform packing, layout hash.
// Also provides the screen-index helper used by the platform generator.
package game_pkg;

  localparam int N_PLAT    = 7;
  localparam int POS_W     = 14;
  localparam int LEN_W     = 4;
  localparam int CAM_W     = 5;
  localparam int N_SCREENS = 32;
  localparam int SCREEN_H  = 480;
  localparam int PLAY_X0   = 120;
  localparam int PLAY_W    = 400;
  localparam int BLOCK_PX  = 16;

  localparam logic [15:0] HASH_MUL = 16'd40503;
  localparam logic [15:0] HASH_XOR = 16'hA5C3;

  localparam logic [POS_W-1:0] PLAT_Y0 = 14'd32;

  // Compare chain against k*SCREEN_H; the last threshold passed wins, so the result saturates.
  function automatic logic [CAM_W-1:0] screen_of(input logic [POS_W-1:0] y);
    logic [CAM_W-1:0] s;
    s = '0;
    for (int k = 1; k < N_SCREENS; k++) begin
      if (y >= POS_W'(k * SCREEN_H)) s = CAM_W'(k);
    end
    return s;
  endfunction

endpackage

// File: rtl/block_gen_slot.sv
// Combinational layout of one platform slot on a given screen: hashed x and length, fixed y.
// Same (level, slot) always yields the same platform, so revisited screens look identical.
module block_gen_slot
  import game_pkg::*;
(
  input  logic [CAM_W-1:0] level_i,
  input  logic [2:0]       slot_i,
  output logic [POS_W-1:0] x_o,
  output logic [POS_W-1:0] y_o,
  output logic [LEN_W-1:0] len_o
);

  logic [7:0]  v;
  logic [7:0]  h_hi;
  logic [2:0]  h_lo;

  assign v = {level_i, slot_i};

  // Only h[15:8] and h[2:0] are consumed; both come from the 16-bit truncated product.
  assign h_hi = 8'(({8'b0, v} * HASH_MUL) >> 8) ^ HASH_XOR[15:8];
  assign h_lo = 3'({8'b0, v} * HASH_MUL) ^ HASH_XOR[2:0];

  assign x_o   = {6'b0, h_hi};
  assign len_o = 4'd2 + {1'b0, h_lo};
  assign y_o   = PLAT_Y0 + {{(POS_W-9){1'b0}}, slot_i, 6'b0};

endmodule

// File: rtl/block_gen.sv
// Platform layout generator: character height -> screen index (1 clk) -> seven platform slots (2 clk).
// No handshake; abs_char_y is sampled every cycle and outputs hold while the screen index is stable.
module block_gen
  import game_pkg::*;
(
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [POS_W-1:0]          abs_char_y,
  output logic [CAM_W-1:0]          camera_y,
  output logic [N_PLAT*POS_W-1:0]   plat_relative_x,
  output logic [N_PLAT*POS_W-1:0]   plat_relative_y,
  output logic [N_PLAT*LEN_W-1:0]   plat_len
);

  logic [CAM_W-1:0]        camera_d, camera_q;
  logic [N_PLAT*POS_W-1:0] x_d, x_q;
  logic [N_PLAT*POS_W-1:0] y_d, y_q;
  logic [N_PLAT*LEN_W-1:0] len_d, len_q;

  assign camera_d = screen_of(abs_char_y);

  // Stage 2 works off the registered index, so the layout trails camera_y by one clock.
  for (genvar g = 0; g < N_PLAT; g++) begin : g_slot
    block_gen_slot u_slot (
      .level_i (camera_q),
      .slot_i  (3'(g)),
      .x_o     (x_d[POS_W*g +: POS_W]),
      .y_o     (y_d[POS_W*g +: POS_W]),
      .len_o   (len_d[LEN_W*g +: LEN_W])
    );
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      camera_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      len_q    <= '0;
    end else begin
      camera_q <= camera_d;
      x_q      <= x_d;
      y_q      <= y_d;
      len_q    <= len_d;
    end
  end

  assign camera_y        = camera_q;
  assign plat_relative_x = x_q;
  assign plat_relative_y = y_q;
  assign plat_len        = len_q;

endmodule

// File: tb/tb_block_gen.sv
// Randomized and swept height stimulus checked against an arithmetic model of the layout rules.
module tb_block_gen;

  logic         sys_clk    = 1'b0;
  logic         sys_rst_n  = 1'b1;
  logic [13:0]  abs_char_y = '0;
  logic [4:0]   camera_y;
  logic [97:0]  plat_relative_x;
  logic [97:0]  plat_relative_y;
  logic [27:0]  plat_len;

  block_gen dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .abs_char_y      (abs_char_y),
    .camera_y        (camera_y),
    .plat_relative_x (plat_relative_x),
    .plat_relative_y (plat_relative_y),
    .plat_len        (plat_len)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Model state: screen seen by stage 1, screen behind the current layout, edges since reset.
  int m_cam   = 0;
  int m_lay   = 0;
  int edges   = 0;
  int mode    = 0;
  int seen_x   [32][7];
  int seen_len [32][7];
  bit seen_v   [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_screen(input int y);
    int s;
    s = y / 480;
    return (s > 31) ? 31 : s;
  endfunction

  function automatic int m_hash(input int lvl, input int i);
    return (((lvl * 8 + i) * 40503) % 65536) ^ 'hA5C3;
  endfunction

  task automatic check_zero();
    chk("rst_cam", 32'(camera_y), 0);
    for (int i = 0; i < 7; i++) begin
      chk("rst_x",   32'(plat_relative_x[14*i +: 14]), 0);
      chk("rst_y",   32'(plat_relative_y[14*i +: 14]), 0);
      chk("rst_len", 32'(plat_len[4*i +: 4]), 0);
    end
  endtask

  task automatic check_outputs();
    int h, x, y, len;
    if (edges >= 1) chk("cam", 32'(camera_y), 32'(m_cam));
    if (edges >= 2) begin
      for (int i = 0; i < 7; i++) begin
        h   = m_hash(m_lay, i);
        x   = int'(plat_relative_x[14*i +: 14]);
        y   = int'(plat_relative_y[14*i +: 14]);
        len = int'(plat_len[4*i +: 4]);
        chk("x",      32'(x),   32'(h >> 8));
        chk("y",      32'(y),   32'(32 + 64 * i));
        chk("len",    32'(len), 32'(2 + (h & 7)));
        chk("fit",    32'(x + len * 16 <= 399), 1);
        chk("lenrng", 32'(len >= 2 && len <= 9), 1);
        if (mode == 1) begin
          seen_x[m_lay][i]   = x;
          seen_len[m_lay][i] = len;
          seen_v[m_lay]      = 1'b1;
        end else if (mode == 2 && seen_v[m_lay]) begin
          chk("updown_x",   32'(x),   32'(seen_x[m_lay][i]));
          chk("updown_len", 32'(len), 32'(seen_len[m_lay][i]));
        end
      end
    end
  endtask

  task automatic tick(input int val);
    abs_char_y = 14'(val);
    @(posedge sys_clk);
    if (sys_rst_n) begin
      m_lay = m_cam;
      m_cam = m_screen(val);
      edges++;
    end
    @(negedge sys_clk);
    check_outputs();
  endtask

  // Assert reset between edges and look at the outputs before the next edge arrives.
  task automatic async_reset();
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_zero();
    edges = 0;
    m_cam = 0;
    m_lay = 0;
    @(negedge sys_clk);
    check_zero();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    for (int l = 0; l < 32; l++) seen_v[l] = 1'b0;

    #1 sys_rst_n = 1'b0;
    #1 check_zero();
    repeat (2) @(negedge sys_clk);
    check_zero();
    sys_rst_n = 1'b1;

    tick(0);
    tick(0);
    chk("s0x",   32'(plat_relative_x[13:0]),  165);
    chk("s0y",   32'(plat_relative_y[13:0]),  32);
    chk("s0len", 32'(plat_len[3:0]),          5);
    chk("s1x",   32'(plat_relative_x[27:14]), 59);
    chk("s1y",   32'(plat_relative_y[27:14]), 96);
    chk("s1len", 32'(plat_len[7:4]),          6);

    tick(479);
    tick(480);
    chk("cam480", 32'(camera_y), 1);
    chk("lag_x0", 32'(plat_relative_x[13:0]), 165);
    tick(480);
    tick(14879);
    tick(14880);
    chk("cam14880", 32'(camera_y), 31);
    tick(16383);
    tick(16383);
    chk("cam_sat", 32'(camera_y), 31);

    mode = 1;
    for (int v = 0; v <= 15000; v += 37) tick(v);
    tick(15000);
    tick(15000);

    mode = 2;
    for (int v = 15000; v >= 0; v -= 37) begin
      if (v == 7000 - (7000 % 37) + (15000 % 37) - 37 * ((15000 % 37) > (7000 % 37) ? 1 : 0))
        async_reset();
      tick(v);
    end
    if (edges > 900) async_reset();

    for (int n = 0; n < 300; n++) begin
      if (n == 150) async_reset();
      tick(int'($urandom_range(0, 16383)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
